// File: rtl/bus_factorial_top.sv
`default_nettype none
// ============================================================================
// Module   : bus_factorial_top
// Brief    : Single-master bus with grant FSM, 64-bit RAM slave and a
//            memory-mapped 128-bit factorial accelerator with interrupt.
//            Optional macro UNMAPPED_PATTERN_EN: unmapped reads return a
//            fixed pattern instead of zero.
// Revision : 1.0 - initial release
// ============================================================================
module bus_factorial_top #(
  parameter int          MEM_WORDS = 256,
  parameter logic [15:0] FACT_BASE = 16'h7000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_req,
  input  logic        m_wr,
  input  logic [15:0] m_addr,
  input  logic [63:0] m_dout,
  output logic        m_grant,
  output logic [63:0] m_din,
  output logic        interrupt
);

  localparam int          c_aw        = $clog2(MEM_WORDS);
  localparam logic [16:0] c_ram_bytes = 17'(MEM_WORDS * 8);
  localparam logic [15:0] c_fact_end  = FACT_BASE + 16'h01FF;

  localparam logic [4:0] c_off_start  = 5'd0;
  localparam logic [4:0] c_off_clear  = 5'd1;
  localparam logic [4:0] c_off_done   = 5'd2;
  localparam logic [4:0] c_off_intren = 5'd3;
  localparam logic [4:0] c_off_oper   = 5'd4;
  localparam logic [4:0] c_off_res_h  = 5'd5;
  localparam logic [4:0] c_off_res_l  = 5'd6;

`ifdef UNMAPPED_PATTERN_EN
  localparam logic [63:0] c_unmapped = 64'hDEAD_BEEF_DEAD_BEEF;
`else
  localparam logic [63:0] c_unmapped = 64'd0;
`endif

  typedef enum logic {
    G_IDLE  = 1'b0,
    G_GRANT = 1'b1
  } grant_state_t;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_BUSY = 2'd1,
    A_DONE = 2'd2
  } acc_state_t;

  grant_state_t  r_gstate;
  acc_state_t    r_astate;
  logic          r_clear;
  logic          r_intr_en;
  logic [63:0]   r_operand;
  logic [63:0]   r_counter;
  logic [127:0]  r_result;
  logic [63:0]   r_mem [MEM_WORDS];

  logic          w_valid;
  logic          w_ram_hit;
  logic          w_acc_hit;
  logic          w_acc_wr;
  logic [4:0]    w_off;
  logic          w_clear;
  logic          w_start;
  logic [127:0]  w_prod;
  logic [63:0]   w_rdata;

  assign w_valid   = m_req & m_grant;
  assign w_ram_hit = ({1'b0, m_addr} < c_ram_bytes);
  assign w_acc_hit = (m_addr >= FACT_BASE) && (m_addr <= c_fact_end);
  assign w_acc_wr  = w_valid & m_wr & w_acc_hit;
  assign w_off     = m_addr[7:3];

  // A clear being written this cycle already acts on the core, so an abort
  // cannot let one more step (or a completion) slip through.
  assign w_clear = r_clear | (w_acc_wr && (w_off == c_off_clear) && m_dout[0]);
  assign w_start = w_acc_wr && (w_off == c_off_start) && m_dout[0] &&
                   (r_astate == A_IDLE);
  assign w_prod  = r_result * {64'd0, r_counter};

  // Bus grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gstate <= G_IDLE;
    end else begin
      case (r_gstate)
        G_IDLE:  if (m_req)  r_gstate <= G_GRANT;
        G_GRANT: if (!m_req) r_gstate <= G_IDLE;
        default: r_gstate <= G_IDLE;
      endcase
    end
  end

  assign m_grant = (r_gstate == G_GRANT);

  // RAM contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (w_valid && m_wr && w_ram_hit) begin
      r_mem[m_addr[c_aw+2:3]] <= m_dout;
    end
  end

  // Accelerator registers and core
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_astate  <= A_IDLE;
      r_clear   <= 1'b0;
      r_intr_en <= 1'b0;
      r_operand <= 64'd0;
      r_counter <= 64'd0;
      r_result  <= 128'd0;
    end else begin
      if (w_acc_wr && (w_off == c_off_clear))  r_clear   <= m_dout[0];
      if (w_acc_wr && (w_off == c_off_intren)) r_intr_en <= m_dout[0];
      if (w_acc_wr && (w_off == c_off_oper) && (r_astate != A_BUSY)) begin
        r_operand <= m_dout;
      end

      if (w_clear) begin
        r_astate  <= A_IDLE;
        r_counter <= 64'd0;
        r_result  <= 128'd0;
      end else begin
        case (r_astate)
          A_IDLE: begin
            if (w_start) begin
              r_result  <= 128'd1;
              r_counter <= r_operand;
              r_astate  <= A_BUSY;
            end
          end
          A_BUSY: begin
            if (r_counter > 64'd1) begin
              r_result  <= w_prod;
              r_counter <= r_counter - 64'd1;
            end else begin
              r_astate <= A_DONE;
            end
          end
          A_DONE:  r_astate <= A_DONE;
          default: r_astate <= A_IDLE;
        endcase
      end
    end
  end

  assign interrupt = (r_astate == A_DONE) & r_intr_en;

  // Combinational read path
  always_comb begin
    w_rdata = 64'd0;
    if (w_valid && !m_wr) begin
      if (w_ram_hit) begin
        w_rdata = r_mem[m_addr[c_aw+2:3]];
      end else if (w_acc_hit) begin
        case (w_off)
          c_off_clear:  w_rdata = {63'd0, r_clear};
          c_off_done:   w_rdata = {62'd0, (r_astate == A_BUSY), (r_astate == A_DONE)};
          c_off_intren: w_rdata = {63'd0, r_intr_en};
          c_off_oper:   w_rdata = r_operand;
          c_off_res_h:  w_rdata = r_result[127:64];
          c_off_res_l:  w_rdata = r_result[63:0];
          default:      w_rdata = 64'd0;
        endcase
      end else begin
        w_rdata = c_unmapped;
      end
    end
  end

  assign m_din = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_factorial_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_factorial_top
// Brief    : Directed self-checking bench for bus_factorial_top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_factorial_top;

  localparam logic [15:0] c_a_start  = 16'h7000;
  localparam logic [15:0] c_a_clear  = 16'h7008;
  localparam logic [15:0] c_a_done   = 16'h7010;
  localparam logic [15:0] c_a_intren = 16'h7018;
  localparam logic [15:0] c_a_oper   = 16'h7020;
  localparam logic [15:0] c_a_res_h  = 16'h7028;
  localparam logic [15:0] c_a_res_l  = 16'h7030;
  localparam logic [15:0] c_a_park   = 16'hFFF0;

`ifdef UNMAPPED_PATTERN_EN
  localparam logic [63:0] c_unm = 64'hDEAD_BEEF_DEAD_BEEF;
`else
  localparam logic [63:0] c_unm = 64'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m_req;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic        m_grant;
  logic [63:0] m_din;
  logic        interrupt;

  int total = 0;
  int bad   = 0;

  bus_factorial_top dut (
    .clk       (clk),
    .reset     (reset),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_dout    (m_dout),
    .m_grant   (m_grant),
    .m_din     (m_din),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fact_model(input int n);
    logic [127:0] r;
    r = 128'd1;
    for (int i = 2; i <= n; i++) r = r * 128'(i);
    return r;
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    m_wr   = 1'b1;
    m_addr = a;
    m_dout = d;
    @(posedge clk);
    #1;
    m_wr   = 1'b0;
    m_addr = c_a_park;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [63:0] d);
    @(negedge clk);
    m_wr   = 1'b0;
    m_addr = a;
    #1;
    d = m_din;
  endtask

  task automatic clear_core();
    bus_write(c_a_clear, 64'd1);
    bus_write(c_a_clear, 64'd0);
  endtask

  // Runs N! and returns cycles from the start edge until done is seen
  task automatic run_fact(input int n, input logic ie, output int cyc);
    clear_core();
    bus_write(c_a_intren, {63'd0, ie});
    bus_write(c_a_oper, 64'(n));
    bus_write(c_a_start, 64'd1);
    m_addr = c_a_done;
    cyc = 0;
    while (cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (m_din[0]) break;
    end
    chk($sformatf("intr_at_done_%0d", n), {127'd0, interrupt}, {127'd0, ie});
  endtask

  task automatic chk_result(input string tag, input logic [127:0] exp);
    logic [63:0] h, l;
    bus_read(c_a_res_h, h);
    bus_read(c_a_res_l, l);
    chk(tag, {h, l}, exp);
  endtask

  initial begin
    logic [63:0] d;
    int          cyc;
    logic        seen;
    logic [63:0] ram_data [3];
    logic [15:0] ram_addr [3];

    ram_data[0] = 64'h1111; ram_addr[0] = 16'h0000;
    ram_data[1] = 64'h2222; ram_addr[1] = 16'h0010;
    ram_data[2] = 64'h3333; ram_addr[2] = 16'h0020;

    reset  = 1'b1;
    m_req  = 1'b0;
    m_wr   = 1'b0;
    m_addr = 16'h0000;
    m_dout = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", {127'd0, m_grant}, 128'd0);
    chk("rst_intr",  {127'd0, interrupt}, 128'd0);
    chk("rst_din",   {64'd0, m_din}, 128'd0);
    @(negedge clk);
    reset = 1'b0;

    // Grant handshake
    @(negedge clk);
    m_req  = 1'b1;
    m_addr = c_a_park;
    #1;
    chk("grant_before_edge", {127'd0, m_grant}, 128'd0);
    @(posedge clk);
    #1;
    chk("grant_up",  {127'd0, m_grant}, 128'd1);
    chk("unmapped_rd", {64'd0, m_din}, {64'd0, c_unm});
    @(negedge clk);
    m_req = 1'b0;
    @(posedge clk);
    #1;
    chk("grant_down", {127'd0, m_grant}, 128'd0);

    // RAM write/readback
    @(negedge clk);
    m_req = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) bus_write(ram_addr[i], ram_data[i]);
    for (int i = 0; i < 3; i++) begin
      bus_read(ram_addr[i], d);
      chk($sformatf("ram_rd_%0d", i), {64'd0, d}, {64'd0, ram_data[i]});
    end
    bus_write(16'h4000, 64'hABCD);
    bus_read(16'h4000, d);
    chk("unmapped_wr_rd", {64'd0, d}, {64'd0, c_unm});

    // Read without grant returns zero
    @(negedge clk);
    m_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_req  = 1'b1;
    m_addr = 16'h0010;
    #1;
    chk("rd_no_grant", {64'd0, m_din}, 128'd0);
    @(posedge clk);
    #1;
    chk("rd_after_grant", {64'd0, m_din}, 128'h2222);

    // 0! and 1!
    run_fact(0, 1'b1, cyc);
    chk("lat_0", 128'(cyc), 128'd1);
    chk_result("res_0", 128'd1);
    run_fact(1, 1'b1, cyc);
    chk("lat_1", 128'(cyc), 128'd1);
    chk_result("res_1", 128'd1);

    // 9! with interrupts disabled, then a start in DONE is ignored
    run_fact(9, 1'b0, cyc);
    chk("lat_9", 128'(cyc), 128'd9);
    chk_result("res_9", 128'h58980);
    bus_read(c_a_done, d);
    chk("opdone_9", {64'd0, d}, 128'd1);
    bus_write(c_a_start, 64'd1);
    bus_read(c_a_done, d);
    chk("start_in_done", {64'd0, d}, 128'd1);
    chk_result("res_9_kept", 128'h58980);

    run_fact(10, 1'b1, cyc);
    chk("lat_10", 128'(cyc), 128'd10);
    chk_result("res_10", 128'h375F00);

    // Clear drops interrupt and result
    bus_write(c_a_clear, 64'd1);
    chk("clr_intr", {127'd0, interrupt}, 128'd0);
    bus_read(c_a_done, d);
    chk("clr_opdone", {64'd0, d}, 128'd0);
    bus_read(c_a_clear, d);
    chk("clr_readback", {64'd0, d}, 128'd1);
    chk_result("clr_result", 128'd0);
    bus_write(c_a_clear, 64'd0);

    // Wide results, including truncation past 128 bits
    run_fact(35, 1'b1, cyc);
    chk("lat_35", 128'(cyc), 128'd35);
    chk_result("res_35", fact_model(35));
    run_fact(200, 1'b1, cyc);
    chk("lat_200", 128'(cyc), 128'd200);
    chk_result("res_200", fact_model(200));
    run_fact(299, 1'b1, cyc);
    chk_result("res_299", fact_model(299));

    // Abort a running operation
    clear_core();
    bus_write(c_a_intren, 64'd1);
    bus_write(c_a_oper, 64'd299);
    bus_write(c_a_start, 64'd1);
    repeat (50) @(posedge clk);
    bus_read(c_a_done, d);
    chk("abort_busy", {64'd0, d}, 128'd2);
    bus_write(c_a_oper, 64'd7);
    bus_read(c_a_oper, d);
    chk("oper_locked_busy", {64'd0, d}, 128'd299);
    bus_write(c_a_clear, 64'd1);
    bus_read(c_a_done, d);
    chk("abort_opdone", {64'd0, d}, 128'd0);
    bus_write(c_a_clear, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 350; i++) begin
      @(posedge clk);
      #1;
      if (interrupt) seen = 1'b1;
    end
    chk("abort_no_intr", {127'd0, seen}, 128'd0);
    chk_result("abort_result", 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
